// File: rtl/fp_int_mul_arbiter.sv
// fp_int_mul_arbiter
//   Shares one bit-serial FP16 x INT4 multiplier among NUM_REQ requesters
//   using round-robin arbitration. The winner's operands are latched and
//   presented to the multiplier, a one-cycle start pulse is issued, and the
//   result (or a watchdog abort) is returned on a valid/ready response channel
//   tagged with the winner's ID.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req[NUM_REQ]             per-requester request level
//   act_in, w_in             packed per-requester activation / weight
//   gnt[NUM_REQ]             one-hot accept pulse (operands sampled that cycle)
//   mul_start                one-cycle start pulse to the multiplier
//   mul_act, mul_w           latched operands to the multiplier
//   mul_busy                 multiplier busy; blocks new grants
//   mul_done                 multiplier result strobe
//   mul_sign/exp/mant        multiplier result
//   rsp_valid, rsp_ready     response handshake
//   rsp_id                   ID of the serviced requester
//   rsp_sign/exp/mant        response result
//   rsp_err                  response is a timeout abort (data forced to 0)
//   idle                     arbiter is waiting for requests
module fp_int_mul_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int ACT_WIDTH = 16,
  parameter int W_WIDTH   = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*ACT_WIDTH-1:0] act_in,
  input  logic [NUM_REQ*W_WIDTH-1:0]   w_in,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         mul_start,
  output logic [ACT_WIDTH-1:0]         mul_act,
  output logic [W_WIDTH-1:0]           mul_w,
  input  logic                         mul_busy,
  input  logic                         mul_done,
  input  logic                         mul_sign,
  input  logic [4:0]                   mul_exp,
  input  logic [13:0]                  mul_mant,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic                         rsp_sign,
  output logic [4:0]                   rsp_exp,
  output logic [13:0]                  rsp_mant,
  output logic                         rsp_err,
  output logic                         idle
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state, state_nxt;

  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       ptr_nxt;
  logic [ID_W-1:0]       win;
  logic                  any_req;
  logic                  grant;
  logic [ACT_WIDTH-1:0]  act_sel;
  logic [W_WIDTH-1:0]    w_sel;
  logic [7:0]            wd;
  logic                  timeout_hit;

  logic [ACT_WIDTH-1:0]  act_p1;
  logic [W_WIDTH-1:0]    w_p1;
  logic [ID_W-1:0]       id_p1;
  logic                  sign_p2;
  logic [4:0]            exp_p2;
  logic [13:0]           mant_p2;
  logic                  err_p2;

  // stage 0: round-robin arbitration and operand select
  always_comb begin
    logic [ID_W-1:0] cand;
    any_req = 1'b0;
    win     = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      // mask-and-reduce keeps the lane lookup free of index-width coupling
      if (!any_req && (|(req & (NUM_REQ'(1) << cand)))) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

  assign grant   = (state == S_IDLE) && any_req && !mul_busy && !rst;
  assign ptr_nxt = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  assign act_sel = ACT_WIDTH'(act_in >> (int'(win) * ACT_WIDTH));
  assign w_sel   = W_WIDTH'(w_in >> (int'(win) * W_WIDTH));

  // watchdog counts completed WAIT cycles; the TIMEOUT-th one aborts
  assign timeout_hit = (wd == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant)                     state_nxt = S_ISSUE;
      S_ISSUE:                                state_nxt = S_WAIT;
      S_WAIT:  if (mul_done || timeout_hit)   state_nxt = S_RESP;
      S_RESP:  if (rsp_ready)                 state_nxt = S_IDLE;
      default:                                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt       = '0;
    mul_start = 1'b0;
    rsp_valid = 1'b0;
    idle      = 1'b0;
    case (state)
      S_IDLE: begin
        idle = 1'b1;
        if (grant) gnt = NUM_REQ'(1) << win;
      end
      S_ISSUE: mul_start = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // stage 1: operand hold (grant -> next grant) and watchdog
  // stage 2: result capture in WAIT, held through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      wd      <= '0;
      act_p1  <= '0;
      w_p1    <= '0;
      id_p1   <= '0;
      sign_p2 <= 1'b0;
      exp_p2  <= '0;
      mant_p2 <= '0;
      err_p2  <= 1'b0;
    end else begin
      if (grant) begin
        act_p1 <= act_sel;
        w_p1   <= w_sel;
        id_p1  <= win;
        ptr    <= ptr_nxt;
      end
      if (state == S_ISSUE)     wd <= '0;
      else if (state == S_WAIT) wd <= wd + 8'd1;
      if (state == S_WAIT) begin
        // a done on the last watchdog cycle still delivers the result
        if (mul_done) begin
          sign_p2 <= mul_sign;
          exp_p2  <= mul_exp;
          mant_p2 <= mul_mant;
          err_p2  <= 1'b0;
        end else if (timeout_hit) begin
          sign_p2 <= 1'b0;
          exp_p2  <= '0;
          mant_p2 <= '0;
          err_p2  <= 1'b1;
        end
      end
    end
  end

  assign mul_act  = act_p1;
  assign mul_w    = w_p1;
  assign rsp_id   = id_p1;
  assign rsp_sign = sign_p2;
  assign rsp_exp  = exp_p2;
  assign rsp_mant = mant_p2;
  assign rsp_err  = err_p2;

endmodule

// File: tb/tb_fp_int_mul_arbiter.sv
// Testbench for fp_int_mul_arbiter: table of directed transactions plus
// hand-written sequences for backpressure, timeout, mid-op reset and busy.
module tb_fp_int_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] act_in;
  logic [15:0] w_in;
  logic [3:0]  gnt;
  logic        mul_start;
  logic [15:0] mul_act;
  logic [3:0]  mul_w;
  logic        mul_busy;
  logic        mul_done;
  logic        mul_sign;
  logic [4:0]  mul_exp;
  logic [13:0] mul_mant;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic        rsp_sign;
  logic [4:0]  rsp_exp;
  logic [13:0] rsp_mant;
  logic        rsp_err;
  logic        idle;

  int n_checks = 0;
  int n_err    = 0;
  int hs_cnt   = 0;

  always #5 clk = ~clk;

  fp_int_mul_arbiter #(
    .NUM_REQ(4), .ID_W(2), .ACT_WIDTH(16), .W_WIDTH(4), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .act_in(act_in), .w_in(w_in),
    .gnt(gnt), .mul_start(mul_start), .mul_act(mul_act), .mul_w(mul_w),
    .mul_busy(mul_busy), .mul_done(mul_done), .mul_sign(mul_sign),
    .mul_exp(mul_exp), .mul_mant(mul_mant), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sign(rsp_sign),
    .rsp_exp(rsp_exp), .rsp_mant(rsp_mant), .rsp_err(rsp_err), .idle(idle)
  );

  // stub multiplier: done pulses stub_lat cycles after the start cycle
  int   stub_lat  = 1;
  logic stub_hang = 1'b0;
  logic stub_act  = 1'b0;
  int   stub_cnt  = 0;

  always @(posedge clk) begin
    if (mul_start) begin
      stub_act <= 1'b1;
      stub_cnt <= stub_lat - 1;
    end else if (stub_act) begin
      if (stub_cnt == 0) stub_act <= 1'b0;
      else               stub_cnt <= stub_cnt - 1;
    end
  end
  assign mul_done = stub_act && (stub_cnt == 0) && !stub_hang;

  always @(posedge clk) if (rsp_valid && rsp_ready) hs_cnt <= hs_cnt + 1;

  typedef struct {
    logic [3:0]  req;
    logic [63:0] act;
    logic [15:0] w;
    int          lat;
    logic        hold;
    logic        s;
    logic [4:0]  e;
    logic [13:0] m;
    logic [3:0]  egnt;
    logic [1:0]  eid;
    logic [15:0] eact;
    logic [3:0]  ew;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(logic [3:0] rq, logic [63:0] a, logic [15:0] w,
                              int lat, logic hold, logic s, logic [4:0] e,
                              logic [13:0] m, logic [3:0] eg, logic [1:0] eid,
                              logic [15:0] ea, logic [3:0] ew);
    vec_t v;
    v.req = rq; v.act = a; v.w = w; v.lat = lat; v.hold = hold;
    v.s = s; v.e = e; v.m = m; v.egnt = eg; v.eid = eid; v.eact = ea; v.ew = ew;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at negedge; returns at the negedge after the handshake.
  task automatic run_op(input vec_t v, input string nm);
    int k;
    int lat_cnt;
    logic bad;
    logic [3:0] g;
    req = v.req; act_in = v.act; w_in = v.w; stub_lat = v.lat;
    mul_sign = v.s; mul_exp = v.e; mul_mant = v.m;
    #1;
    k = 0;
    while (gnt == 4'b0 && k < 30) begin @(negedge clk); #1; k++; end
    check({nm, " gnt"}, gnt, v.egnt);
    g = gnt;
    @(negedge clk);
    if (!v.hold) req = req & ~g;
    #1;
    check({nm, " start"}, mul_start, 1'b1);
    check({nm, " act"}, mul_act, v.eact);
    check({nm, " w"}, mul_w, v.ew);
    lat_cnt = 0;
    bad = 1'b0;
    do begin
      @(negedge clk); #1; lat_cnt++;
      if (!rsp_valid && (mul_start || gnt != 4'b0)) bad = 1'b1;
    end while (!rsp_valid && lat_cnt < 40);
    check({nm, " latency"}, lat_cnt, v.lat + 1);
    check({nm, " quiet"}, bad, 1'b0);
    check({nm, " id"}, rsp_id, v.eid);
    check({nm, " result"}, {rsp_err, rsp_sign, rsp_exp, rsp_mant}, {1'b0, v.s, v.e, v.m});
    @(negedge clk); #1;
    check({nm, " valid drop"}, {rsp_valid, idle}, 2'b01);
  endtask

  initial begin
    int k;
    int hs0;
    logic bad;
    logic [20:0] snap;
    rst = 1'b1; req = 4'hF; act_in = '0; w_in = '0; mul_busy = 1'b0;
    rsp_ready = 1'b1; mul_sign = 1'b0; mul_exp = '0; mul_mant = '0;

    for (int i = 0; i < 8; i++)
      tbl[i] = mk(4'hF, 64'h4444_3333_2222_1111, 16'h4321, 1, 1'b1,
                  i[0], 5'(i + 1), 14'(i * 'h111), 4'(1 << (i % 4)), 2'(i % 4),
                  16'(16'h1111 * ((i % 4) + 1)), 4'((i % 4) + 1));
    tbl[8]  = mk(4'b0100, 64'h0000_3C00_0000_0000, 16'h0300, 4, 1'b0,
                 1'b0, 5'h0F, 14'h0C00, 4'b0100, 2'd2, 16'h3C00, 4'h3);
    tbl[9]  = mk(4'b0011, 64'h0000_0000_5555_C000, 16'h00F8, 2, 1'b0,
                 1'b1, 5'h1F, 14'h3FFF, 4'b0001, 2'd0, 16'hC000, 4'h8);
    tbl[10] = mk(4'b0110, 64'h0000_ABCD_7BFF_0000, 16'h07F0, 15, 1'b0,
                 1'b0, 5'h00, 14'h0001, 4'b0010, 2'd1, 16'h7BFF, 4'hF);
    tbl[11] = mk(4'b1001, 64'hFFFF_0000_0000_1234, 16'h9005, 14, 1'b0,
                 1'b1, 5'h10, 14'h2AAA, 4'b1000, 2'd3, 16'hFFFF, 4'h9);

    // reset state, with every request high
    @(negedge clk); @(negedge clk); #1;
    check("reset idle", idle, 1'b1);
    check("reset gnt", gnt, 4'b0);
    check("reset outs", {mul_start, rsp_valid, rsp_err, mul_act, mul_w, rsp_id},
          '0);
    rst = 1'b0; req = 4'h0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // backpressure: lane1 keeps requesting while lane0's response stalls
    rsp_ready = 1'b0;
    req = 4'b0011; act_in = 64'h0000_0000_BC00_4248; w_in = 16'h00A6;
    stub_lat = 3; mul_sign = 1'b1; mul_exp = 5'h05; mul_mant = 14'h1234;
    #1;
    check("bp gnt", gnt, 4'b0001);
    @(negedge clk); req = 4'b0010; #1;
    check("bp operands", {mul_start, mul_act, mul_w}, {1'b1, 16'h4248, 4'h6});
    k = 0;
    while (!rsp_valid && k < 20) begin @(negedge clk); #1; k++; end
    check("bp first valid", {rsp_valid, rsp_id, rsp_err, rsp_sign, rsp_exp, rsp_mant},
          {1'b1, 2'd0, 1'b0, 1'b1, 5'h05, 14'h1234});
    snap = {rsp_id, rsp_err, rsp_sign, rsp_exp, rsp_mant};
    mul_exp = 5'h1A; mul_mant = 14'h0555; mul_sign = 1'b0;
    hs0 = hs_cnt;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (!rsp_valid || gnt != 4'b0 ||
          {rsp_id, rsp_err, rsp_sign, rsp_exp, rsp_mant} != snap) bad = 1'b1;
    end
    check("bp stable", bad, 1'b0);
    check("bp no handshake", hs_cnt, hs0);
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("bp one handshake", hs_cnt, hs0 + 1);
    check("bp next gnt", {rsp_valid, gnt}, {1'b0, 4'b0010});
    run_op(mk(4'b0010, 64'h0000_0000_BC00_4248, 16'h00A6, 2, 1'b0,
              1'b0, 5'h1A, 14'h0555, 4'b0010, 2'd1, 16'hBC00, 4'hA), "bp lane1");

    // timeout: multiplier never finishes
    stub_hang = 1'b1;
    req = 4'b0100; act_in = 64'h0000_1234_0000_0000; w_in = 16'h0700;
    #1;
    check("to gnt", gnt, 4'b0100);
    @(negedge clk); req = 4'b0000; #1;
    check("to start", mul_start, 1'b1);
    k = 0;
    do begin @(negedge clk); #1; k++; end while (!rsp_valid && k < 40);
    check("to latency", k, 16);
    check("to response", {rsp_id, rsp_err, rsp_sign, rsp_exp, rsp_mant},
          {2'd2, 1'b1, 1'b0, 5'h00, 14'h0000});
    @(negedge clk); #1;
    check("to back idle", {rsp_valid, idle}, 2'b01);
    stub_hang = 1'b0;
    run_op(mk(4'b1000, 64'h5A5A_0000_0000_0000, 16'hC000, 1, 1'b0,
              1'b1, 5'h0E, 14'h0200, 4'b1000, 2'd3, 16'h5A5A, 4'hC), "to next");

    // reset in WAIT drops the operation; late done must be ignored
    req = 4'b0010; act_in = 64'h0000_0000_1357_0000; w_in = 16'h00B0;
    stub_lat = 5; mul_sign = 1'b1; mul_exp = 5'h07; mul_mant = 14'h0777;
    #1;
    check("rst gnt", gnt, 4'b0010);
    @(negedge clk); req = 4'b0000;
    @(negedge clk); @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("rst state", {idle, rsp_valid, mul_start, mul_act, rsp_id}, {1'b1, 1'b0, 1'b0, 16'h0, 2'd0});
    hs0 = hs_cnt;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (rsp_valid || !idle || gnt != 4'b0) bad = 1'b1;
    end
    check("rst no response", bad, 1'b0);
    check("rst no handshake", hs_cnt, hs0);
    run_op(mk(4'b1111, 64'h1111_2222_3333_4444, 16'h1234, 1, 1'b0,
              1'b0, 5'h01, 14'h0001, 4'b0001, 2'd0, 16'h4444, 4'h4), "rst ptr0");

    // busy gating
    mul_busy = 1'b1; req = 4'b0001;
    #1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (gnt != 4'b0 || !idle) bad = 1'b1;
      @(negedge clk); #1;
    end
    check("busy no gnt", bad, 1'b0);
    mul_busy = 1'b0; #1;
    check("busy release gnt", gnt, 4'b0001);
    run_op(mk(4'b0001, 64'h0000_0000_0000_3800, 16'h000D, 2, 1'b0,
              1'b1, 5'h12, 14'h1FFF, 4'b0001, 2'd0, 16'h3800, 4'hD), "busy op");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
